// File: rtl/id_scan_ctrl_pkg.sv
// Shared types for the identifier scanner: byte classes, matcher and controller states.
// Combinational helper only; no latency, no flow control.
package id_pkg;

  typedef enum logic [1:0] {CLS_LETTER, CLS_DIGIT, CLS_TERM, CLS_OTHER} char_cls_t;
  typedef enum logic [1:0] {S0, S1, S2} match_st_t;
  typedef enum logic {SCAN, REPORT} ctrl_st_t;

  // Terminator wins over the letter/digit ranges so any byte can serve as TERM.
  function automatic char_cls_t classify(input logic [7:0] c, input logic [7:0] term);
    if (c == term) return CLS_TERM;
    if ((c >= 8'h41 && c <= 8'h5A) || (c >= 8'h61 && c <= 8'h7A)) return CLS_LETTER;
    if (c >= 8'h30 && c <= 8'h39) return CLS_DIGIT;
    return CLS_OTHER;
  endfunction

endpackage

// File: rtl/id_scan_ctrl_if.sv
// Byte stream in, per-string result out; master is the environment, slave the controller.
// Valid/ready on both sides; result held by the slave until accepted.
interface id_scan_ctrl_if #(parameter int CNT_W = 8, parameter int LEN_W = 8);
  logic             in_valid;
  logic             in_ready;
  logic [7:0]       in_char;
  logic             res_valid;
  logic             res_ready;
  logic [CNT_W-1:0] res_count;
  logic [LEN_W-1:0] res_maxlen;
  logic             res_ovf;

  modport master (output in_valid, in_char, res_ready,
                  input  in_ready, res_valid, res_count, res_maxlen, res_ovf);
  modport slave  (input  in_valid, in_char, res_ready,
                  output in_ready, res_valid, res_count, res_maxlen, res_ovf);
endinterface

// File: rtl/id_scan_ctrl_match_core.sv
// Letter->digit matcher and saturating token length; next values are combinational from state/class.
// Registers advance one step per asserted step; clear dominates; no backpressure of its own.
module id_match_core
  import id_pkg::*;
#(
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             step,
  input  logic             clear,
  input  char_cls_t        cls,
  output match_st_t        state,
  output match_st_t        next_state,
  output logic [LEN_W-1:0] len_next,
  output logic             sat
);

  logic [LEN_W-1:0] len;
  logic             grow;

  always_comb begin
    next_state = S0;
    grow       = 1'b0;
    len_next   = '0;
    case (cls)
      CLS_LETTER: begin
        next_state = S1;
        if (state == S1) grow = 1'b1;
        else             len_next = LEN_W'(1);
      end
      CLS_DIGIT: begin
        if (state != S0) begin
          next_state = S2;
          grow       = 1'b1;
        end
      end
      default: ;
    endcase
    sat = grow && (len == '1);
    if (grow) len_next = sat ? len : len + LEN_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S0;
      len   <= '0;
    end else if (clear) begin
      state <= S0;
      len   <= '0;
    end else if (step) begin
      state <= next_state;
      len   <= len_next;
    end
  end

endmodule

// File: rtl/id_scan_ctrl.sv
// Counts identifiers per TERM-delimited string and reports count/longest/overflow.
// Result 1 cycle after TERM; input stalls (in_ready=0) while a result waits for res_ready.
module id_scan_ctrl
  import id_pkg::*;
#(
  parameter int         CNT_W = 8,
  parameter int         LEN_W = 8,
  parameter logic [7:0] TERM  = 8'h00
) (
  input logic         clk,
  input logic         rst_n,
  id_scan_ctrl_if.slave bus
);

  ctrl_st_t         ctrl, ctrl_nx;
  char_cls_t        cls;
  match_st_t        m_state, m_next;
  logic [LEN_W-1:0] len_next;
  logic             len_sat;
  logic             fire, step, is_term, cnt_inc, ovf_nx;
  logic [CNT_W-1:0] count, res_count;
  logic [LEN_W-1:0] maxlen, res_maxlen;
  logic             ovf, res_ovf;

  assign cls     = classify(bus.in_char, TERM);
  assign is_term = (cls == CLS_TERM);
  assign fire    = bus.in_valid && (ctrl == SCAN);
  assign step    = fire && !is_term;
  assign cnt_inc = step && (m_state == S1) && (m_next == S2);
  assign ovf_nx  = ovf || len_sat || (cnt_inc && (count == '1));

  id_match_core #(.LEN_W(LEN_W)) u_core (
    .clk        (clk),
    .rst_n      (rst_n),
    .step       (step),
    .clear      (fire && is_term),
    .cls        (cls),
    .state      (m_state),
    .next_state (m_next),
    .len_next   (len_next),
    .sat        (len_sat)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ctrl <= SCAN;
    else        ctrl <= ctrl_nx;
  end

  always_comb begin
    ctrl_nx = ctrl;
    case (ctrl)
      SCAN:    if (fire && is_term) ctrl_nx = REPORT;
      REPORT:  if (bus.res_ready)   ctrl_nx = SCAN;
      default: ctrl_nx = SCAN;
    endcase
  end

  // Handshake outputs come straight from the state register: no input-to-output paths.
  assign bus.in_ready   = (ctrl == SCAN);
  assign bus.res_valid  = (ctrl == REPORT);
  assign bus.res_count  = res_count;
  assign bus.res_maxlen = res_maxlen;
  assign bus.res_ovf    = res_ovf;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count      <= '0;
      maxlen     <= '0;
      ovf        <= 1'b0;
      res_count  <= '0;
      res_maxlen <= '0;
      res_ovf    <= 1'b0;
    end else if (fire && is_term) begin
      res_count  <= count;
      res_maxlen <= maxlen;
      res_ovf    <= ovf;
      count      <= '0;
      maxlen     <= '0;
      ovf        <= 1'b0;
    end else if (step) begin
      if (cnt_inc && (count != '1)) count <= count + CNT_W'(1);
      if ((m_next == S2) && (len_next > maxlen)) maxlen <= len_next;
      ovf <= ovf_nx;
    end
  end

endmodule

// File: tb/tb_id_scan_ctrl.sv
// Directed bench: two controllers (8/8 and narrow 2/3 counters) share one stimulus stream.
// Results are collected at acceptance and compared against hand-derived values.
module tb_id_scan_ctrl;
  import id_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic [7:0] in_char;
  logic       res_ready;
  int         tests = 0;
  int         fails = 0;

  typedef struct packed {
    logic [7:0] cnt;
    logic [7:0] mx;
    logic       ovf;
  } res_t;

  res_t qa[$];
  res_t qb[$];

  id_scan_ctrl_if #(.CNT_W(8), .LEN_W(8)) ia ();
  id_scan_ctrl_if #(.CNT_W(2), .LEN_W(3)) ib ();

  id_scan_ctrl #(.CNT_W(8), .LEN_W(8), .TERM(8'h00)) u_a (.clk(clk), .rst_n(rst_n), .bus(ia.slave));
  id_scan_ctrl #(.CNT_W(2), .LEN_W(3), .TERM(8'h00)) u_b (.clk(clk), .rst_n(rst_n), .bus(ib.slave));

  assign ia.in_valid  = in_valid;
  assign ia.in_char   = in_char;
  assign ia.res_ready = res_ready;
  assign ib.in_valid  = in_valid;
  assign ib.in_char   = in_char;
  assign ib.res_ready = res_ready;

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst_n && ia.res_valid && ia.res_ready)
      qa.push_back('{ia.res_count, ia.res_maxlen, ia.res_ovf});
    if (rst_n && ib.res_valid && ib.res_ready)
      qb.push_back('{{6'b0, ib.res_count}, {5'b0, ib.res_maxlen}, ib.res_ovf});
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] c);
    in_char  = c;
    in_valid = 1'b1;
    for (int k = 0; k < 50 && !ia.in_ready; k++) begin
      @(posedge clk); #1;
    end
    chk("in_ready_wait", {31'b0, ia.in_ready}, 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i]);
  endtask

  task automatic expect_res(input string tag, input bit sel, input int c, input int m, input int o);
    res_t r;
    r = '0;
    for (int k = 0; k < 60 && (sel ? qb.size() : qa.size()) == 0; k++) begin
      @(posedge clk); #1;
    end
    chk({tag, "_arrive"}, (sel ? qb.size() : qa.size()) > 0 ? 32'd1 : 32'd0, 32'd1);
    if (sel && qb.size() > 0) r = qb.pop_front();
    else if (!sel && qa.size() > 0) r = qa.pop_front();
    chk({tag, "_count"},  {24'b0, r.cnt}, c);
    chk({tag, "_maxlen"}, {24'b0, r.mx},  m);
    chk({tag, "_ovf"},    {31'b0, r.ovf}, o);
  endtask

  task automatic wait_res_valid();
    for (int k = 0; k < 50 && !ia.res_valid; k++) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_char   = 8'h00;
    res_ready = 1'b1;
    #1;
    chk("rst_in_ready",  {31'b0, ia.in_ready},  32'd1);
    chk("rst_res_valid", {31'b0, ia.res_valid}, 32'd0);
    chk("rst_res_count", {24'b0, ia.res_count}, 32'd0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // 1: one long identifier; narrow instance saturates the length
    send_str("ABCD0123"); send_byte(8'h00); in_valid = 1'b0;
    expect_res("t1a", 1'b0, 1, 8, 0);
    expect_res("t1b", 1'b1, 1, 7, 1);

    // 2: two tokens in one string, then a string with no identifier
    send_str("AB12CD3"); send_byte(8'h00);
    send_str("12AB");    send_byte(8'h00); in_valid = 1'b0;
    expect_res("t2a1", 1'b0, 2, 4, 0);
    expect_res("t2a2", 1'b0, 0, 0, 0);
    expect_res("t2b1", 1'b1, 2, 4, 0);
    expect_res("t2b2", 1'b1, 0, 0, 0);

    // 3: result held under backpressure, bytes offered meanwhile are ignored
    res_ready = 1'b0;
    send_str("A1"); send_byte(8'h00);
    in_char = "Z";
    wait_res_valid();
    for (int i = 0; i < 5; i++) begin
      chk("t3_res_valid", {31'b0, ia.res_valid},  32'd1);
      chk("t3_in_ready",  {31'b0, ia.in_ready},   32'd0);
      chk("t3_count",     {24'b0, ia.res_count},  32'd1);
      chk("t3_maxlen",    {24'b0, ia.res_maxlen}, 32'd2);
      in_char = (i == 2) ? 8'h00 : 8'h61 + 8'(i);
      @(posedge clk); #1;
    end
    in_valid  = 1'b0;
    res_ready = 1'b1;
    expect_res("t3a", 1'b0, 1, 2, 0);
    expect_res("t3b", 1'b1, 1, 2, 0);
    repeat (3) @(posedge clk); #1;
    chk("t3_single_result", qa.size(), 0);

    // 4: saturation of count (narrow CNT_W) and of length (narrow LEN_W)
    send_str("A1 B2 C3 D4"); send_byte(8'h00);
    send_str("ABCDEFG12");   send_byte(8'h00); in_valid = 1'b0;
    expect_res("t4a1", 1'b0, 4, 2, 0);
    expect_res("t4a2", 1'b0, 1, 9, 0);
    expect_res("t4b1", 1'b1, 3, 2, 1);
    expect_res("t4b2", 1'b1, 1, 7, 1);

    // 5: asynchronous reset mid-string discards the partial string
    send_str("AB1"); in_valid = 1'b0;
    chk("t5_count_pre", {24'b0, u_a.count}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_count_rst",  {24'b0, u_a.count},  32'd0);
    chk("t5_maxlen_rst", {24'b0, u_a.maxlen}, 32'd0);
    chk("t5_in_ready",   {31'b0, ia.in_ready}, 32'd1);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    send_str("C9"); send_byte(8'h00); in_valid = 1'b0;
    expect_res("t5a", 1'b0, 1, 2, 0);
    expect_res("t5b", 1'b1, 1, 2, 0);

    // 5b: reset while a result is pending loses it
    res_ready = 1'b0;
    send_str("Q7"); send_byte(8'h00); in_valid = 1'b0;
    wait_res_valid();
    chk("t5r_valid_pre", {31'b0, ia.res_valid}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("t5r_valid_rst", {31'b0, ia.res_valid}, 32'd0);
    chk("t5r_count_rst", {24'b0, ia.res_count}, 32'd0);
    #1 rst_n = 1'b1;
    res_ready = 1'b1;
    repeat (4) @(posedge clk); #1;
    chk("t5r_lost", qa.size(), 0);

    // 6: empty string back-to-back with a real one, valid held high throughout
    send_byte(8'h00); send_str("Z0"); send_byte(8'h00); in_valid = 1'b0;
    expect_res("t6a1", 1'b0, 0, 0, 0);
    expect_res("t6a2", 1'b0, 1, 2, 0);
    expect_res("t6b1", 1'b1, 0, 0, 0);
    expect_res("t6b2", 1'b1, 1, 2, 0);

    repeat (4) @(posedge clk); #1;
    chk("end_no_extra_a", qa.size(), 0);
    chk("end_no_extra_b", qb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
